// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared fetch-side types and constants          rev 1.0
// ============================================================================
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          INSTR_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : sync FIFO of {pc, instr} entries with flush   rev 1.0
// ============================================================================
import cpu_pkg::*;

module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  fetch_entry_t             i_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Flush has priority: a pop coinciding with a flush is simply absorbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit : PC/FSM owner feeding decode via a small FIFO   rev 1.0
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter int          FIFO_DEPTH = 2,
  parameter int          ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              fault
);

  import cpu_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_inflight_pc;
  logic             r_inflight;
  logic             r_fault;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_occupancy;
  logic             w_pop;
  logic             w_redirect_ok;
  logic             w_redirect_bad;
  logic             w_flush;
  logic             w_issue;
  logic             w_capture;
  fetch_entry_t     w_push_data;
  fetch_entry_t     w_head;

  assign w_pop          = if_valid & if_ready;
  assign w_redirect_ok  = redirect_valid & (r_state != ST_FAULT) &  is_word_aligned(redirect_pc);
  assign w_redirect_bad = redirect_valid & (r_state != ST_FAULT) & ~is_word_aligned(redirect_pc);
  assign w_flush        = redirect_valid | (r_state == ST_FAULT);

  // Slots already committed (buffered + in memory) after this cycle's pop.
  assign w_occupancy = w_count + CNT_W'(r_inflight) - CNT_W'(w_pop);
  assign w_issue     = (r_state == ST_RUN) & fetch_en & ~redirect_valid &
                       (w_occupancy < CNT_W'(FIFO_DEPTH));
  assign w_capture   = r_inflight & ~w_flush;

  assign w_push_data.pc    = r_inflight_pc;
  assign w_push_data.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_flush (w_flush),
    .i_push  (w_capture),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_valid (if_valid),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_fault       <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + 32'd4;
      end
      if (w_redirect_ok) begin
        r_pc <= redirect_pc;
      end
      if (w_redirect_bad) begin
        r_state <= ST_FAULT;
        r_fault <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: if (fetch_en)  r_state <= ST_RUN;
          ST_RUN:  if (!fetch_en) r_state <= ST_IDLE;
          default:                r_state <= ST_FAULT;
        endcase
      end
    end
  end

  assign imem_addr = ADDR_W'(r_pc[31:2]);
  assign if_instr  = w_head.instr;
  assign if_pc     = w_head.pc;
  assign fault     = r_fault;

endmodule
`default_nettype wire
